// File: rtl/window_ctrl.sv
// Frame sequencer for the window datapath: arm, trigger, settling skip, an N-sample
// enable window, then drain the window pipeline and count completed frames.
module window_ctrl #(
  parameter int unsigned N               = 1024,
  parameter int unsigned SKIP_WIDTH      = 10,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       continuous,
  input  logic                       abort,
  input  logic                       trigger,
  input  logic [SKIP_WIDTH-1:0]      skip,
  input  logic                       adc_valid,
  input  logic                       win_dvalid,
  output logic                       win_en,
  output logic                       win_clk_en,
  output logic                       win_rst_n,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] N_CNT  = CW'(N);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, RUN, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [SKIP_WIDTH-1:0]      skip_ctr_q, skip_ctr_d;
  logic [CW-1:0]              in_ctr_q, in_ctr_d;
  logic [CW-1:0]              out_ctr_q, out_ctr_d;
  logic                       clk_en_dly;
  logic                       out_fire;
  logic                       win_en_d, win_rst_n_d, out_valid_d, busy_d;
  logic                       frame_done_d, overrun_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_d;

  // The window pipeline always advances on every sample strobe.
  assign win_clk_en = adc_valid;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    skip_ctr_d    = skip_ctr_q;
    in_ctr_d      = in_ctr_q;
    out_ctr_d     = out_ctr_q;
    overrun_d     = overrun;
    frame_count_d = frame_count;
    frame_done_d  = 1'b0;

    // A fresh window output exists only in the cycle after a strobe.
    out_fire = win_dvalid && clk_en_dly && (state_q == RUN || state_q == DRAIN)
               && (out_ctr_q != N_CNT);
    if (out_fire) out_ctr_d = out_ctr_q + CW'(1);

    if (arm) overrun_d = 1'b0;
    else if (trigger && (state_q == SETTLE || state_q == RUN || state_q == DRAIN))
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (trigger) begin
          skip_ctr_d = skip;
          in_ctr_d   = '0;
          out_ctr_d  = '0;
          state_d    = (skip == '0) ? RUN : SETTLE;
        end
      end
      SETTLE: begin
        if (adc_valid) begin
          skip_ctr_d = skip_ctr_q - SKIP_WIDTH'(1);
          if (skip_ctr_q == SKIP_WIDTH'(1)) begin
            in_ctr_d  = '0;
            out_ctr_d = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (adc_valid) begin
          in_ctr_d = in_ctr_q + CW'(1);
          if (in_ctr_q == N_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Pulse frame_done first, then leave on the following cycle.
        if (frame_done) begin
          state_d = continuous ? ARMED : IDLE;
        end else if (out_ctr_q == N_CNT) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count + FRAME_CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every other event in the same cycle.
    if (abort) begin
      state_d       = IDLE;
      skip_ctr_d    = '0;
      in_ctr_d      = '0;
      out_ctr_d     = '0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count;
      overrun_d     = overrun;
    end

    win_en_d    = (state_d == RUN);
    busy_d      = (state_d == SETTLE || state_d == RUN || state_d == DRAIN);
    out_valid_d = out_fire && !abort;
    win_rst_n_d = !abort;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      skip_ctr_q  <= '0;
      in_ctr_q    <= '0;
      out_ctr_q   <= '0;
      clk_en_dly  <= 1'b0;
      win_en      <= 1'b0;
      win_rst_n   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      skip_ctr_q  <= skip_ctr_d;
      in_ctr_q    <= in_ctr_d;
      out_ctr_q   <= out_ctr_d;
      clk_en_dly  <= win_clk_en;
      win_en      <= win_en_d;
      win_rst_n   <= win_rst_n_d;
      out_valid   <= out_valid_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      overrun     <= overrun_d;
      frame_count <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_window_ctrl.sv
// Scoreboard bench for window_ctrl with N=8 and a 2-bit frame counter; a small
// two-stage window model supplies win_dvalid.
module tb_window_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned SW  = 10;
  localparam int unsigned FCW = 2;

  logic           clk, rst_n, arm, continuous, abort, trigger;
  logic [SW-1:0]  skip;
  logic           adc_valid, win_dvalid;
  logic           win_en, win_clk_en, win_rst_n, out_valid, busy, frame_done, overrun;
  logic [FCW-1:0] frame_count;

  window_ctrl #(.N(N), .SKIP_WIDTH(SW), .FRAME_CNT_WIDTH(FCW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .continuous(continuous), .abort(abort),
    .trigger(trigger), .skip(skip), .adc_valid(adc_valid), .win_dvalid(win_dvalid),
    .win_en(win_en), .win_clk_en(win_clk_en), .win_rst_n(win_rst_n),
    .out_valid(out_valid), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .frame_count(frame_count)
  );

  typedef struct {int outs; int ens; int fc;} exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int fc_model = 0;
  int adc_period = 0;
  int mon_outs = 0;
  int mon_ens = 0;
  logic win_s1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Window model: output for input k appears after strobe k+1.
  always @(posedge clk) begin
    if (!win_rst_n) begin
      win_s1     <= 1'b0;
      win_dvalid <= 1'b0;
    end else if (win_clk_en) begin
      win_s1     <= win_en;
      win_dvalid <= win_s1;
    end
  end

  initial begin
    int ph;
    ph = 0;
    adc_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      adc_valid = (adc_period != 0) && (ph % adc_period == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tallies outputs and enabled strobes, pops at each frame_done.
  always @(negedge clk) begin
    if (!rst_n || !win_rst_n) begin
      mon_outs = 0;
      mon_ens  = 0;
    end else begin
      if (out_valid) mon_outs++;
      if (win_en && adc_valid) mon_ens++;
      if (frame_done) begin
        check("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("frame_outputs", mon_outs, e.outs);
          check("frame_en_strobes", mon_ens, e.ens);
          check("frame_count", int'(frame_count), e.fc);
        end
        mon_outs = 0;
        mon_ens  = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic expect_frame();
    fc_model = (fc_model + 1) % (1 << FCW);
    sb.push_back('{outs: N, ens: N, fc: fc_model});
  endtask

  // Trigger and count discarded strobes until win_en rises; ends on that negedge.
  task automatic do_frame(input int skip_v, input bit push);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    skip = SW'(skip_v);
    trigger = 1'b1;
    if (push) expect_frame();
    step();
    trigger = 1'b0;
    forever begin
      @(negedge clk);
      if (win_en) break;
      if (adc_valid) cnt++;
      guard++;
      if (guard > 5000) break;
    end
    check("skipped_samples", cnt, skip_v);
  endtask

  task automatic wait_run_strobes(input int k);
    int n;
    n = 0;
    for (int g = 0; g < 2000; g++) begin
      if (win_en && adc_valid) n++;
      if (n == k) break;
      @(negedge clk);
    end
    check("run_strobes_reached", n, k);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 5000; g++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", int'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw;
    rst_n = 1'b0; arm = 1'b0; continuous = 1'b0; abort = 1'b0; trigger = 1'b0;
    skip = '0;
    #1;
    check("rst_win_en", int'(win_en), 0);
    check("rst_win_rst_n", int'(win_rst_n), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_frame_count", int'(frame_count), 0);
    #12 rst_n = 1'b1;
    step();
    check("win_rst_n_release", int'(win_rst_n), 1);

    // Single frame, skip 3, strobe every 2nd cycle.
    adc_period = 2;
    pulse_arm();
    do_frame(3, 1'b1);
    wait_done();
    step(); step();
    check("idle_busy", int'(busy), 0);
    trigger = 1'b1; step(); trigger = 1'b0; step();
    check("idle_trigger_busy", int'(busy), 0);
    check("idle_trigger_overrun", int'(overrun), 0);

    // Overrun: trigger during RUN, frame still completes.
    pulse_arm();
    do_frame(2, 1'b1);
    wait_run_strobes(3);
    @(posedge clk); #1;
    trigger = 1'b1; step(); trigger = 1'b0;
    check("overrun_set", int'(overrun), 1);
    wait_done();
    step();
    check("overrun_sticky", int'(overrun), 1);
    pulse_arm();
    check("overrun_cleared", int'(overrun), 0);

    // Abort after the 5th RUN sample.
    do_frame(0, 1'b0);
    wait_run_strobes(5);
    @(posedge clk); #1;
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_win_en", int'(win_en), 0);
    check("abort_win_rst_n_low", int'(win_rst_n), 0);
    check("abort_busy", int'(busy), 0);
    step();
    check("abort_win_rst_n_high", int'(win_rst_n), 1);
    repeat (30) step();
    check("abort_frame_count", int'(frame_count), fc_model);
    pulse_arm();
    do_frame(1, 1'b1);
    wait_done();
    step(); step();

    // Continuous, zero skip, strobe every cycle, 3 triggers 20 cycles apart.
    continuous = 1'b1;
    adc_period = 1;
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      skip = '0;
      trigger = 1'b1;
      expect_frame();
      step();
      trigger = 1'b0;
      repeat (19) step();
    end
    check("cont_frame_count", int'(frame_count), fc_model);
    check("cont_overrun", int'(overrun), 0);
    check("cont_busy", int'(busy), 0);

    // Async reset during DRAIN.
    continuous = 1'b0;
    adc_period = 2;
    do_frame(0, 1'b0);
    gw = 0;
    while (win_en && gw < 100) begin
      @(negedge clk);
      gw++;
    end
    check("drain_reached", int'(busy && !win_en), 1);
    #2 rst_n = 1'b0;
    #1;
    fc_model = 0;
    check("ar_win_en", int'(win_en), 0);
    check("ar_win_rst_n", int'(win_rst_n), 0);
    check("ar_out_valid", int'(out_valid), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_frame_done", int'(frame_done), 0);
    check("ar_overrun", int'(overrun), 0);
    check("ar_frame_count", int'(frame_count), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("ar_win_rst_n_held", int'(win_rst_n), 0);
    step();
    check("ar_win_rst_n_rise", int'(win_rst_n), 1);

    // Counter wrap: 5 frames on a 2-bit counter, then a 1023-sample skip.
    continuous = 1'b1;
    adc_period = 1;
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      skip = '0;
      trigger = 1'b1;
      expect_frame();
      step();
      trigger = 1'b0;
      repeat (19) step();
    end
    check("wrap_frame_count", int'(frame_count), 1);
    do_frame(1023, 1'b1);
    wait_done();
    repeat (4) step();
    check("final_frame_count", int'(frame_count), 2);
    check("scoreboard_drained", int'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
